axi_mem_responder: RTL and testbench

- AXI4 slave endpoint that answers bursts arriving from the AXI node on one slave port.
- Converts each burst into beats on a single-port, word-wide SRAM interface with 1-cycle read latency; the memory is always granted.
- Sits between an axi_node slave port and a memory macro, as the responder for core, debug and SPI initiators.
- Data path is 32 bits only.

---
 rtl/axi_mem_responder_if.sv | 72 +++++++
 rtl/axi_mem_responder.sv | 196 +++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 565 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_responder_if.sv
// AXI4 slave-port bundle seen by axi_mem_responder.
// Member names follow the responder's point of view.
interface axi_mem_responder_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4
);
  logic                      aw_valid_i;
  logic                      aw_ready_o;
  logic [AXI_ID_WIDTH-1:0]   aw_id_i;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_i;
  logic [7:0]                aw_len_i;
  logic [1:0]                aw_burst_i;

  logic                      w_valid_i;
  logic                      w_ready_o;
  logic [31:0]               w_data_i;
  logic [3:0]                w_strb_i;
  logic                      w_last_i;

  logic                      b_valid_o;
  logic                      b_ready_i;
  logic [AXI_ID_WIDTH-1:0]   b_id_o;
  logic [1:0]                b_resp_o;

  logic                      ar_valid_i;
  logic                      ar_ready_o;
  logic [AXI_ID_WIDTH-1:0]   ar_id_i;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr_i;
  logic [7:0]                ar_len_i;
  logic [1:0]                ar_burst_i;

  logic                      r_valid_o;
  logic                      r_ready_i;
  logic [AXI_ID_WIDTH-1:0]   r_id_o;
  logic [31:0]               r_data_o;
  logic [1:0]                r_resp_o;
  logic                      r_last_o;

  modport slave (
    input  aw_valid_i, aw_id_i, aw_addr_i,
    input  aw_len_i, aw_burst_i,
    output aw_ready_o,
    input  w_valid_i, w_data_i, w_strb_i,
    input  w_last_i,
    output w_ready_o,
    output b_valid_o, b_id_o, b_resp_o,
    input  b_ready_i,
    input  ar_valid_i, ar_id_i, ar_addr_i,
    input  ar_len_i, ar_burst_i,
    output ar_ready_o,
    output r_valid_o, r_id_o, r_data_o,
    output r_resp_o, r_last_o,
    input  r_ready_i
  );

  modport master (
    output aw_valid_i, aw_id_i, aw_addr_i,
    output aw_len_i, aw_burst_i,
    input  aw_ready_o,
    output w_valid_i, w_data_i, w_strb_i,
    output w_last_i,
    input  w_ready_o,
    input  b_valid_o, b_id_o, b_resp_o,
    output b_ready_i,
    output ar_valid_i, ar_id_i, ar_addr_i,
    output ar_len_i, ar_burst_i,
    input  ar_ready_o,
    input  r_valid_o, r_id_o, r_data_o,
    input  r_resp_o, r_last_o,
    output r_ready_i
  );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 slave that turns bursts into beats on a
// single-port word SRAM with 1-cycle read latency.
module axi_mem_responder #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MEM_ADDR_WIDTH = 14
) (
  input  logic                      clk,
  input  logic                      rst_n,
  axi_mem_responder_if.slave        axi,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]               mem_wdata_o,
  output logic [3:0]                mem_be_o,
  input  logic [31:0]               mem_rdata_i
);

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    WRESP,
    READ
  } state_t;

  state_t state_q, state_d;

  // 1 when the last granted address went to the write side
  logic                      rr_wr_q;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                len_q;
  logic [1:0]                burst_q;
  logic [8:0]                cnt_q;
  logic [8:0]                rcnt_q;
  logic                      err_q;
  logic                      infl_q;
  logic [31:0]               fifo_q [2];
  logic                      wr_ptr_q;
  logic                      rd_ptr_q;
  logic [1:0]                occ_q;

  logic       grant_w;
  logic       grant_r;
  logic       w_beat;
  logic       last_w;
  logic       r_valid;
  logic       r_pop;
  logic       issue;
  logic       wrap;
  logic [8:0] n_beats;
  logic [1:0] occ_left;

  logic unused_addr;
  assign unused_addr = ^{
    axi.aw_addr_i[AXI_ADDR_WIDTH-1:MEM_ADDR_WIDTH+2],
    axi.aw_addr_i[1:0],
    axi.ar_addr_i[AXI_ADDR_WIDTH-1:MEM_ADDR_WIDTH+2],
    axi.ar_addr_i[1:0]
  };

  assign n_beats  = {1'b0, len_q} + 9'd1;
  assign wrap     = burst_q == BURST_WRAP;
  assign w_beat   = (state_q == WRITE) && axi.w_valid_i;
  assign last_w   = cnt_q == {1'b0, len_q};
  assign r_valid  = (state_q == READ) && (occ_q != 2'd0);
  assign r_pop    = r_valid && axi.r_ready_i;
  assign occ_left = occ_q - {1'b0, r_pop};

  // A slot freed by this cycle's pop may be refilled at once
  assign issue = (state_q == READ) &&
                 (cnt_q != n_beats) &&
                 ((occ_left + {1'b0, infl_q}) < 2'd2);

  always_comb begin
    grant_w = 1'b0;
    grant_r = 1'b0;
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        grant_w = axi.aw_valid_i &&
                  (!axi.ar_valid_i || !rr_wr_q);
        grant_r = axi.ar_valid_i && !grant_w;
        if (grant_w) begin
          state_d = WRITE;
        end else if (grant_r) begin
          state_d = READ;
        end
      end
      WRITE: begin
        if (w_beat && last_w) state_d = WRESP;
      end
      WRESP: begin
        if (axi.b_ready_i) state_d = IDLE;
      end
      READ: begin
        if (r_pop && axi.r_last_o) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign axi.aw_ready_o = grant_w;
  assign axi.ar_ready_o = grant_r;
  assign axi.w_ready_o  = state_q == WRITE;

  assign axi.b_valid_o = state_q == WRESP;
  assign axi.b_id_o    = id_q;
  assign axi.b_resp_o  = (err_q || wrap) ? RESP_SLVERR
                                         : RESP_OKAY;

  assign axi.r_valid_o = r_valid;
  assign axi.r_id_o    = id_q;
  assign axi.r_data_o  = fifo_q[rd_ptr_q];
  assign axi.r_resp_o  = wrap ? RESP_SLVERR : RESP_OKAY;
  assign axi.r_last_o  = r_valid &&
                         (rcnt_q == {1'b0, len_q});

  assign mem_req_o   = (w_beat || issue) && !wrap;
  assign mem_we_o    = w_beat && !wrap;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = mem_we_o ? axi.w_data_i : '0;
  assign mem_be_o    = mem_we_o ? axi.w_strb_i : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_wr_q <= 1'b1;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_w || grant_r) begin
        rr_wr_q <= grant_w;
        cnt_q   <= '0;
        rcnt_q  <= '0;
        err_q   <= 1'b0;
        if (grant_w) begin
          id_q    <= axi.aw_id_i;
          addr_q  <= axi.aw_addr_i[MEM_ADDR_WIDTH+1:2];
          len_q   <= axi.aw_len_i;
          burst_q <= axi.aw_burst_i;
        end else begin
          id_q    <= axi.ar_id_i;
          addr_q  <= axi.ar_addr_i[MEM_ADDR_WIDTH+1:2];
          len_q   <= axi.ar_len_i;
          burst_q <= axi.ar_burst_i;
        end
      end
      if (w_beat || issue) begin
        cnt_q <= cnt_q + 9'd1;
        if (burst_q == BURST_INCR) begin
          addr_q <= addr_q + 1'b1;
        end
      end
      if (w_beat && (axi.w_last_i != last_w)) begin
        err_q <= 1'b1;
      end
      if (r_pop) begin
        rcnt_q <= rcnt_q + 9'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_q    <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= '0;
    end else begin
      infl_q <= issue;
      if (infl_q) begin
        fifo_q[wr_ptr_q] <= wrap ? '0 : mem_rdata_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (r_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_left + {1'b0, infl_q};
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder with an
// SRAM model and a word-array reference memory.
`timescale 1ns/1ps
module tb_axi_mem_responder;
  localparam int AW = 32;
  localparam int IW = 4;
  localparam int MW = 14;
  localparam int WORDS = 1 << MW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_mem_responder_if #(
    .AXI_ADDR_WIDTH(AW),
    .AXI_ID_WIDTH(IW)
  ) bus ();

  logic          mem_req;
  logic          mem_we;
  logic [MW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic [31:0]   mem_rdata;

  axi_mem_responder #(
    .AXI_ADDR_WIDTH(AW),
    .AXI_ID_WIDTH(IW),
    .MEM_ADDR_WIDTH(MW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .axi(bus),
    .mem_req_o(mem_req),
    .mem_we_o(mem_we),
    .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_be_o(mem_be),
    .mem_rdata_i(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] sram [WORDS];
  logic [31:0] ref_mem [WORDS];
  logic        sram_init = 1'b0;

  always @(posedge clk) begin
    if (!sram_init) begin
      for (int i = 0; i < WORDS; i++) sram[i] <= '0;
      sram_init <= 1'b1;
    end else if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b])
            sram[mem_addr][8*b+:8] <= mem_wdata[8*b+:8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  typedef struct packed {
    logic [MW-1:0] a;
    logic [31:0]   d;
    logic [3:0]    be;
  } wr_t;

  wr_t wq[$];
  byte gq[$];
  int  n_reads = 0;
  int  out_cnt = 0;
  int  max_out = 0;
  int  both_ready = 0;

  always @(negedge clk) begin
    if (mem_req && mem_we)
      wq.push_back(wr_t'{a: mem_addr, d: mem_wdata,
                         be: mem_be});
    if (mem_req && !mem_we) begin
      n_reads++;
      out_cnt++;
    end
    if (bus.r_valid_o && bus.r_ready_i) out_cnt--;
    if (!rst_n) out_cnt = 0;
    if (out_cnt > max_out) max_out = out_cnt;
    if (bus.aw_ready_o && bus.ar_ready_o) both_ready++;
    if (bus.ar_valid_i && bus.ar_ready_o) gq.push_back("R");
    if (bus.aw_valid_i && bus.aw_ready_o) gq.push_back("W");
  end

  logic [31:0] wdat [256];
  logic [3:0]  wstb [256];

  function automatic logic [MW-1:0] word_of(
    input logic [31:0] a, input int k,
    input logic [1:0] bt);
    logic [31:0] x;
    x = (bt == 2'b01) ? a + 32'(4 * k) : a;
    return x[MW+1:2];
  endfunction

  task automatic idle_inputs();
    bus.aw_valid_i = 0; bus.aw_id_i = 0;
    bus.aw_addr_i = 0;  bus.aw_len_i = 0;
    bus.aw_burst_i = 0;
    bus.w_valid_i = 0;  bus.w_data_i = 0;
    bus.w_strb_i = 0;   bus.w_last_i = 0;
    bus.b_ready_i = 0;
    bus.ar_valid_i = 0; bus.ar_id_i = 0;
    bus.ar_addr_i = 0;  bus.ar_len_i = 0;
    bus.ar_burst_i = 0;
    bus.r_ready_i = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic send_aw(input logic [IW-1:0] id,
    input logic [31:0] a, input logic [7:0] len,
    input logic [1:0] bt);
    int t = 0;
    logic hs = 0;
    bus.aw_valid_i = 1; bus.aw_id_i = id;
    bus.aw_addr_i = a;  bus.aw_len_i = len;
    bus.aw_burst_i = bt;
    while (!hs && t < 300) begin
      @(negedge clk);
      hs = bus.aw_ready_o;
      @(posedge clk); #1;
      t++;
    end
    bus.aw_valid_i = 0;
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL aw_handshake: no aw_ready in %0d cycles", t);
    end
  endtask

  task automatic send_ar(input logic [IW-1:0] id,
    input logic [31:0] a, input logic [7:0] len,
    input logic [1:0] bt);
    int t = 0;
    logic hs = 0;
    bus.ar_valid_i = 1; bus.ar_id_i = id;
    bus.ar_addr_i = a;  bus.ar_len_i = len;
    bus.ar_burst_i = bt;
    while (!hs && t < 300) begin
      @(negedge clk);
      hs = bus.ar_ready_o;
      @(posedge clk); #1;
      t++;
    end
    bus.ar_valid_i = 0;
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL ar_handshake: no ar_ready in %0d cycles", t);
    end
  endtask

  task automatic do_write(input logic [IW-1:0] id,
    input logic [31:0] a, input logic [7:0] len,
    input logic [1:0] bt, input int lastpos);
    int n = 0;
    int t = 0;
    logic hs;
    logic [1:0] exp_resp;
    int exp_n;
    wr_t e;
    logic [MW-1:0] w;
    wq.delete();
    send_aw(id, a, len, bt);
    while (n <= int'(len) && t < 3000) begin
      t++;
      if ($urandom_range(0, 3) == 0) begin
        bus.w_valid_i = 0;
        @(posedge clk); #1;
      end
      bus.w_valid_i = 1;
      bus.w_data_i = wdat[n];
      bus.w_strb_i = wstb[n];
      bus.w_last_i = (n == lastpos);
      @(negedge clk);
      hs = bus.w_ready_o;
      @(posedge clk); #1;
      if (hs) n++;
    end
    bus.w_valid_i = 0;
    bus.w_last_i = 0;
    checks++;
    if (n != int'(len) + 1) begin
      errors++;
      $display("FAIL w_beats: got %0d need %0d", n, len + 1);
    end
    bus.b_ready_i = 0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({bus.b_valid_o, bus.b_id_o} !== {1'b1, id}) begin
        errors++;
        $display("FAIL b_hold: got v=%b id=%0h need v=1 id=%0h",
                 bus.b_valid_o, bus.b_id_o, id);
      end
      @(posedge clk); #1;
    end
    exp_resp = (bt == 2'b10 || lastpos != int'(len))
               ? 2'b10 : 2'b00;
    bus.b_ready_i = 1;
    @(negedge clk);
    checks++;
    if ({bus.b_valid_o, bus.b_id_o, bus.b_resp_o} !==
        {1'b1, id, exp_resp}) begin
      errors++;
      $display("FAIL b_resp: got v=%b id=%0h resp=%0d need 1 %0h %0d",
               bus.b_valid_o, bus.b_id_o, bus.b_resp_o,
               id, exp_resp);
    end
    @(posedge clk); #1;
    bus.b_ready_i = 0;
    @(negedge clk);
    checks++;
    if (bus.b_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL b_done: b_valid got %b need 0", bus.b_valid_o);
    end
    @(posedge clk); #1;
    exp_n = (bt == 2'b10) ? 0 : int'(len) + 1;
    checks++;
    if (wq.size() != exp_n) begin
      errors++;
      $display("FAIL mem_wr_count: got %0d need %0d",
               wq.size(), exp_n);
    end
    for (int i = 0; i < exp_n && i < wq.size(); i++) begin
      e = wr_t'{a: word_of(a, i, bt), d: wdat[i],
                be: wstb[i]};
      checks++;
      if (wq[i] !== e) begin
        errors++;
        $display("FAIL mem_wr[%0d]: got %0h/%0h/%0h need %0h/%0h/%0h",
                 i, wq[i].a, wq[i].d, wq[i].be, e.a, e.d, e.be);
      end
    end
    for (int i = 0; i < exp_n; i++) begin
      w = word_of(a, i, bt);
      for (int b = 0; b < 4; b++)
        if (wstb[i][b]) ref_mem[w][8*b+:8] = wdat[i][8*b+:8];
    end
  endtask

  task automatic do_read(input logic [IW-1:0] id,
    input logic [31:0] a, input logic [7:0] len,
    input logic [1:0] bt, input int mode,
    output logic [31:0] first);
    int k = 0;
    int t = 0;
    int lat = -1;
    int vcyc = 0;
    int r0;
    int exp_rd;
    logic stalled = 0;
    logic wr;
    logic [31:0] ed;
    logic [1:0]  er;
    logic        el;
    first = '0;
    wr = bt == 2'b10;
    r0 = n_reads;
    bus.r_ready_i = 1;
    send_ar(id, a, len, bt);
    while (k <= int'(len) && t < 3000) begin
      @(negedge clk);
      t++;
      if (stalled) begin
        checks++;
        if (bus.r_valid_o !== 1'b1) begin
          errors++;
          $display("FAIL r_stall_valid: r_valid got %b need 1",
                   bus.r_valid_o);
        end
      end
      stalled = 0;
      if (bus.r_valid_o) begin
        if (lat < 0) lat = t - 1;
        vcyc++;
        ed = wr ? 32'h0 : ref_mem[word_of(a, k, bt)];
        er = wr ? 2'b10 : 2'b00;
        el = (k == int'(len));
        checks++;
        if ({bus.r_data_o, bus.r_last_o, bus.r_resp_o,
             bus.r_id_o} !== {ed, el, er, id}) begin
          errors++;
          $display("FAIL r_beat[%0d]: got d=%0h l=%b r=%0d id=%0h need d=%0h l=%b r=%0d id=%0h",
                   k, bus.r_data_o, bus.r_last_o, bus.r_resp_o,
                   bus.r_id_o, ed, el, er, id);
        end
        if (k == 0) first = bus.r_data_o;
        if (bus.r_ready_i) k++;
        else stalled = 1;
      end
      @(posedge clk); #1;
      if (mode == 0) bus.r_ready_i = 1;
      else if (mode == 1) bus.r_ready_i = ~bus.r_ready_i;
      else bus.r_ready_i = 1'($urandom_range(0, 1));
    end
    bus.r_ready_i = 1;
    checks++;
    if (k != int'(len) + 1) begin
      errors++;
      $display("FAIL r_beats: got %0d need %0d", k, len + 1);
    end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL r_latency: got %0d need 2", lat);
    end
    if (mode == 0) begin
      checks++;
      if (vcyc != int'(len) + 1) begin
        errors++;
        $display("FAIL r_throughput: valid cycles %0d need %0d",
                 vcyc, len + 1);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.r_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL r_extra: r_valid got %b need 0",
               bus.r_valid_o);
    end
    @(posedge clk); #1;
    exp_rd = wr ? 0 : int'(len) + 1;
    checks++;
    if (n_reads - r0 != exp_rd) begin
      errors++;
      $display("FAIL mem_rd_count: got %0d need %0d",
               n_reads - r0, exp_rd);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.aw_ready_o, bus.ar_ready_o, bus.w_ready_o,
         bus.b_valid_o, bus.r_valid_o, mem_req} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b need 000000",
               {bus.aw_ready_o, bus.ar_ready_o, bus.w_ready_o,
                bus.b_valid_o, bus.r_valid_o, mem_req});
    end
    checks++;
    if ({bus.b_id_o, bus.b_resp_o, bus.r_id_o, bus.r_data_o,
         bus.r_resp_o, bus.r_last_o, mem_wdata,
         mem_be} !== '0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%0h bid=%0h rid=%0h need 0",
               bus.r_data_o, bus.b_id_o, bus.r_id_o);
    end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_incr();
    logic [31:0] f;
    for (int i = 0; i < 4; i++) begin
      wdat[i] = 32'hA0 + 32'(i);
      wstb[i] = 4'hF;
    end
    do_write(4'h5, 32'h100, 8'd3, 2'b01, 3);
    do_read(4'h6, 32'h100, 8'd3, 2'b01, 0, f);
    checks++;
    if (f !== 32'hA0) begin
      errors++;
      $display("FAIL incr_first: got %0h need a0", f);
    end
  endtask

  task automatic test_stall();
    logic [31:0] f;
    for (int i = 0; i < 8; i++) begin
      wdat[i] = $urandom;
      wstb[i] = 4'hF;
    end
    do_write(4'h2, 32'h400, 8'd7, 2'b01, 7);
    max_out = 0;
    do_read(4'h3, 32'h400, 8'd7, 2'b01, 1, f);
    checks++;
    if (max_out > 2) begin
      errors++;
      $display("FAIL outstanding: got %0d need <=2", max_out);
    end
    do_read(4'h4, 32'h400, 8'd7, 2'b01, 0, f);
  endtask

  task automatic test_arbitration();
    logic [31:0] f;
    apply_reset();
    gq.delete();
    both_ready = 0;
    wdat[0] = 32'hCAFE0000;
    wdat[1] = 32'hCAFE0001;
    wstb[0] = 4'hF;
    wstb[1] = 4'hF;
    fork
      do_read(4'h9, 32'h100, 8'd1, 2'b01, 0, f);
      do_write(4'hA, 32'h600, 8'd1, 2'b01, 1);
    join
    checks++;
    if (gq.size() != 2 || gq[0] != "R" || gq[1] != "W") begin
      errors++;
      $display("FAIL arb_order: got n=%0d first=%c need R then W",
               gq.size(), gq.size() > 0 ? gq[0] : "-");
    end
    checks++;
    if (both_ready != 0) begin
      errors++;
      $display("FAIL arb_both_ready: got %0d cycles need 0",
               both_ready);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] f;
    wdat[0] = 32'h11223344;
    wstb[0] = 4'h5;
    do_write(4'h1, 32'h200, 8'd0, 2'b01, 0);
    do_read(4'h1, 32'h200, 8'd0, 2'b01, 0, f);
    checks++;
    if (f !== 32'h00220044) begin
      errors++;
      $display("FAIL strobe_readback: got %0h need 00220044", f);
    end
  endtask

  task automatic test_errors();
    logic [31:0] f;
    for (int i = 0; i < 4; i++) begin
      wdat[i] = $urandom;
      wstb[i] = 4'hF;
    end
    do_write(4'h7, 32'h300, 8'd3, 2'b10, 3);
    do_read(4'h8, 32'h300, 8'd3, 2'b10, 2, f);
    do_write(4'hB, 32'h340, 8'd3, 2'b01, 1);
    do_write(4'hC, 32'h380, 8'd3, 2'b01, 99);
    do_write(4'hD, 32'hFFFF_FFF8, 8'd3, 2'b01, 3);
    do_read(4'hE, 32'hFFFF_FFF8, 8'd3, 2'b01, 2, f);
  endtask

  task automatic test_reset_mid();
    logic [31:0] f;
    int k = 0;
    int t = 0;
    int vseen = 0;
    for (int i = 0; i < 8; i++) begin
      wdat[i] = $urandom;
      wstb[i] = 4'hF;
    end
    do_write(4'h3, 32'h800, 8'd7, 2'b01, 7);
    bus.r_ready_i = 1;
    send_ar(4'h3, 32'h800, 8'd7, 2'b01);
    while (t < 50) begin
      @(negedge clk);
      t++;
      if (bus.r_valid_o && k == 2) break;
      if (bus.r_valid_o) k++;
    end
    rst_n = 0;
    #1;
    checks++;
    if ({bus.r_valid_o, mem_req, bus.ar_ready_o,
         bus.aw_ready_o, bus.w_ready_o,
         bus.b_valid_o} !== 6'b0 || k != 2) begin
      errors++;
      $display("FAIL reset_async: got %b k=%0d need 000000 k=2",
               {bus.r_valid_o, mem_req, bus.ar_ready_o,
                bus.aw_ready_o, bus.w_ready_o, bus.b_valid_o}, k);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (6) begin
      @(negedge clk);
      if (bus.r_valid_o || bus.b_valid_o) vseen++;
    end
    checks++;
    if (vseen != 0) begin
      errors++;
      $display("FAIL reset_no_beats: got %0d valid cycles need 0",
               vseen);
    end
    @(posedge clk); #1;
    do_read(4'h4, 32'h800, 8'd7, 2'b01, 0, f);
  endtask

  task automatic test_long();
    logic [31:0] f;
    for (int i = 0; i < 256; i++) begin
      wdat[i] = $urandom;
      wstb[i] = 4'hF;
    end
    do_write(4'hF, 32'h2000, 8'd255, 2'b01, 255);
    do_read(4'hF, 32'h2000, 8'd255, 2'b01, 0, f);
  endtask

  task automatic test_random();
    logic [31:0] f;
    logic [31:0] a;
    logic [7:0]  len;
    logic [1:0]  bt;
    for (int it = 0; it < 8; it++) begin
      a = $urandom;
      len = 8'($urandom_range(0, 15));
      bt = $urandom_range(0, 1) ? 2'b01 : 2'b00;
      for (int i = 0; i <= int'(len); i++) begin
        wdat[i] = $urandom;
        wstb[i] = 4'($urandom_range(0, 15));
      end
      do_write(4'($urandom), a, len, bt, int'(len));
      bt = $urandom_range(0, 1) ? 2'b01 : 2'b00;
      do_read(4'($urandom), a,
              8'($urandom_range(0, 15)), bt,
              $urandom_range(0, 2), f);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
    test_reset();
    test_incr();
    test_stall();
    test_arbitration();
    test_strobe();
    test_errors();
    test_reset_mid();
    test_long();
    test_random();
    checks++;
    if (max_out > 2) begin
      errors++;
      $display("FAIL outstanding_total: got %0d need <=2",
               max_out);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
